// File: rtl/connected_core_feeder_if.sv
// Bundle of job-source, core-request and monitoring signals around the feeder.
// The feeder takes the slave side; whoever drives jobs and requests takes the master side.
interface connected_core_feeder_if #(
   parameter int EXTRA_DATA_WIDTH = 10,
   parameter int FIFO_DEPTH_LOG2  = 5
);
   logic                        inValid;
   logic                        inReady;
   logic [127:0]                inGraph;
   logic [5:0]                  inConnectCount;
   logic [EXTRA_DATA_WIDTH-1:0] inExtraData;
   logic [FIFO_DEPTH_LOG2:0]    fillLevel;
   logic                        almostFull;
   logic                        request;
   logic                        start;
   logic [127:0]                graphOut;
   logic [5:0]                  connectCountOut;
   logic [EXTRA_DATA_WIDTH-1:0] extraDataOut;
   logic [31:0]                 launchedCount;
   logic [31:0]                 idleSlotCount;

   modport slave (
      input  inValid, inGraph, inConnectCount, inExtraData, request,
      output inReady, fillLevel, almostFull, start, graphOut, connectCountOut,
             extraDataOut, launchedCount, idleSlotCount
   );

   modport master (
      output inValid, inGraph, inConnectCount, inExtraData, request,
      input  inReady, fillLevel, almostFull, start, graphOut, connectCountOut,
             extraDataOut, launchedCount, idleSlotCount
   );
endinterface

// File: rtl/connected_core_feeder.sv
// Job FIFO feeding the count-connected core: each request is answered exactly
// DATA_IN_LATENCY cycles later with either a launched job or an all-zero idle slot.
module connected_core_feeder #(
   parameter int EXTRA_DATA_WIDTH   = 10,
   parameter int DATA_IN_LATENCY    = 4,
   parameter int FIFO_DEPTH_LOG2    = 5,
   parameter int ALMOST_FULL_MARGIN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   connected_core_feeder_if.slave  bus
);
   localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;
   localparam int W        = 128 + 6 + EXTRA_DATA_WIDTH;
   localparam int NS       = DATA_IN_LATENCY - 1;
   localparam int AF_LEVEL = DEPTH - ALMOST_FULL_MARGIN;

   typedef logic [FIFO_DEPTH_LOG2:0]   level_t;
   typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_data_q;

   ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   level_t      fill_q, fill_d;
   logic        almost_full_q, almost_full_d;
   logic [31:0] launched_q, launched_d, idle_q, idle_d;
   logic        in_ready, push, pop, idle_slot;

   logic         vld_q  [0:NS];
   logic         vld_d  [0:NS];
   logic [W-1:0] pipe_q [1:NS];
   logic [W-1:0] pipe_d [1:NS];

   // Gated by rst so the source sees no room while the feeder is held in reset.
   assign in_ready = (fill_q < level_t'(DEPTH)) && !rst;

   always_comb begin
      push          = bus.inValid & in_ready;
      pop           = bus.request & ~rst & (fill_q != '0);
      idle_slot     = bus.request & ~rst & (fill_q == '0);
      wr_ptr_d      = wr_ptr_q + ptr_t'(push);
      rd_ptr_d      = rd_ptr_q + ptr_t'(pop);
      fill_d        = fill_q + level_t'(push) - level_t'(pop);
      almost_full_d = (fill_d >= level_t'(AF_LEVEL));
      launched_d    = launched_q + 32'(pop);
      idle_d        = idle_q + 32'(idle_slot);
   end

   // Plain RAM with a registered read; the read only happens for a real pop.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= {bus.inGraph, bus.inConnectCount, bus.inExtraData};
      if (pop)
         rd_data_q <= mem[rd_ptr_q];
   end

   assign vld_d[0] = pop;

   generate
      for (genvar gi = 1; gi <= NS; gi++) begin : g_stage
         assign vld_d[gi] = vld_q[gi-1];
         if (gi == 1) begin : g_first
            // Stale RAM data is masked here so idle slots carry zeros downstream.
            assign pipe_d[gi] = vld_q[0] ? rd_data_q : '0;
         end else begin : g_rest
            assign pipe_d[gi] = pipe_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         almost_full_q <= 1'b0;
         launched_q    <= '0;
         idle_q        <= '0;
         for (int i = 0; i <= NS; i++) vld_q[i] <= 1'b0;
         for (int i = 1; i <= NS; i++) pipe_q[i] <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fill_q        <= fill_d;
         almost_full_q <= almost_full_d;
         launched_q    <= launched_d;
         idle_q        <= idle_d;
         for (int i = 0; i <= NS; i++) vld_q[i] <= vld_d[i];
         for (int i = 1; i <= NS; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   assign bus.inReady       = in_ready;
   assign bus.fillLevel     = fill_q;
   assign bus.almostFull    = almost_full_q;
   assign bus.launchedCount = launched_q;
   assign bus.idleSlotCount = idle_q;
   assign bus.start         = vld_q[NS];
   assign {bus.graphOut, bus.connectCountOut, bus.extraDataOut} = pipe_q[NS];
endmodule

// File: tb/tb_connected_core_feeder.sv
// Self-checking bench for connected_core_feeder: directed table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_connected_core_feeder;
   localparam int EW    = 10;
   localparam int L     = 4;
   localparam int LOG2  = 5;
   localparam int DEPTH = 32;
   localparam int AF    = 28;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   connected_core_feeder_if #(.EXTRA_DATA_WIDTH(EW), .FIFO_DEPTH_LOG2(LOG2)) bus ();

   connected_core_feeder #(
      .EXTRA_DATA_WIDTH(EW), .DATA_IN_LATENCY(L),
      .FIFO_DEPTH_LOG2(LOG2), .ALMOST_FULL_MARGIN(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic [127:0]  g;
      logic [5:0]    cc;
      logic [EW-1:0] tag;
   } job_t;

   typedef struct {
      int   due;
      job_t job;
   } launch_t;

   typedef struct {
      logic          v;
      logic [EW-1:0] tag;
      logic          req;
      logic          exp_start;
      logic [EW-1:0] exp_tag;
      int            exp_fill;
   } vec_t;

   job_t          fifo_m [$];
   launch_t       sched  [$];
   logic [EW-1:0] seen_tags [$];
   logic [31:0]   m_launched, m_idle;
   int            edge_n = 0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      fifo_m.delete();
      sched.delete();
      m_launched = '0;
      m_idle     = '0;
   endtask

   task automatic drive(input logic v, input job_t j, input logic req);
      bus.inValid        = v;
      bus.inGraph        = j.g;
      bus.inConnectCount = j.cc;
      bus.inExtraData    = j.tag;
      bus.request        = req;
   endtask

   // One clock: apply the model's view of the edge, then compare every output at negedge.
   task automatic step();
      bit      do_push, do_pop, do_idle;
      job_t    j, e;
      logic    e_start;
      launch_t l;
      do_push = !rst && bus.inValid && (fifo_m.size() < DEPTH);
      do_pop  = !rst && bus.request && (fifo_m.size() != 0);
      do_idle = !rst && bus.request && (fifo_m.size() == 0);
      j.g   = bus.inGraph;
      j.cc  = bus.inConnectCount;
      j.tag = bus.inExtraData;
      @(posedge clk);
      edge_n++;
      if (rst) begin
         model_reset();
      end else begin
         if (do_pop) begin
            l.job = fifo_m.pop_front();
            l.due = edge_n + L - 1;
            sched.push_back(l);
            m_launched++;
         end
         if (do_idle) begin
            m_idle++;
            $display("edge %0d: idle slot", edge_n);
         end
         if (do_push) fifo_m.push_back(j);
      end
      e = '{g: '0, cc: '0, tag: '0};
      e_start = 1'b0;
      if (sched.size() > 0 && sched[0].due == edge_n) begin
         e = sched[0].job;
         e_start = 1'b1;
         sched.delete(0);
      end
      @(negedge clk);
      if (bus.start) begin
         seen_tags.push_back(bus.extraDataOut);
         $display("edge %0d: launch tag=%0h cc=%0d", edge_n, bus.extraDataOut, bus.connectCountOut);
      end
      chk("start",        bus.start,           e_start);
      chk("graphOut",     bus.graphOut,        e.g);
      chk("connectCount", bus.connectCountOut, e.cc);
      chk("extraData",    bus.extraDataOut,    e.tag);
      chk("fillLevel",    bus.fillLevel,       fifo_m.size());
      chk("almostFull",   bus.almostFull,      (!rst && fifo_m.size() >= AF));
      chk("inReady",      bus.inReady,         (!rst && fifo_m.size() < DEPTH));
      chk("launched",     bus.launchedCount,   m_launched);
      chk("idleSlots",    bus.idleSlotCount,   m_idle);
   endtask

   function automatic job_t mk(input logic [127:0] g, input logic [5:0] cc, input logic [EW-1:0] tag);
      job_t j;
      j.g = g; j.cc = cc; j.tag = tag;
      return j;
   endfunction

   vec_t vt [10];

   initial begin
      model_reset();
      drive(1'b1, mk(128'h55, 6'd1, 10'd1), 1'b1);

      // Reset held for 5 cycles; requests and offered jobs must be ignored.
      for (int i = 0; i < 5; i++) step();
      rst = 1'b0;
      drive(1'b0, mk('0, '0, '0), 1'b0);
      step();
      chk("post_reset_inReady", bus.inReady, 1'b1);
      chk("post_reset_fill", bus.fillLevel, 0);

      // Directed table: single job, empty-FIFO request with same-cycle push.
      vt[0] = '{1'b1, 10'd7, 1'b0, 1'b0, 10'd0, 1};
      vt[1] = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 0};
      vt[2] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 0};
      vt[3] = '{1'b1, 10'd9, 1'b1, 1'b0, 10'd0, 1};
      vt[4] = '{1'b0, 10'd0, 1'b0, 1'b1, 10'd7, 1};
      vt[5] = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 0};
      vt[6] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 0};
      vt[7] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 0};
      vt[8] = '{1'b0, 10'd0, 1'b0, 1'b1, 10'd9, 0};
      vt[9] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 0};
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].v, mk(128'h3, 6'd2, vt[i].tag), vt[i].req);
         step();
         chk($sformatf("vec%0d_start", i), bus.start, vt[i].exp_start);
         chk($sformatf("vec%0d_fill", i), bus.fillLevel, vt[i].exp_fill);
         if (vt[i].exp_start) begin
            chk($sformatf("vec%0d_tag", i), bus.extraDataOut, vt[i].exp_tag);
            chk($sformatf("vec%0d_graph", i), bus.graphOut, 128'h3);
            chk($sformatf("vec%0d_cc", i), bus.connectCountOut, 6'd2);
         end
      end
      chk("table_launched", bus.launchedCount, 32'd2);
      chk("table_idle", bus.idleSlotCount, 32'd1);

      // Fill to the brim: 33 offers, the last must be held off.
      for (int i = 0; i < 33; i++) begin
         drive(1'b1, mk(128'(i), 6'(i), 10'(i)), 1'b0);
         step();
         if (i == 26) chk("almostFull_27", bus.almostFull, 1'b0);
         if (i == 27) chk("almostFull_28", bus.almostFull, 1'b1);
      end
      chk("full_fill", bus.fillLevel, 32);
      chk("full_inReady", bus.inReady, 1'b0);
      seen_tags.delete();
      for (int i = 0; i < 32 + L; i++) begin
         drive(1'b0, mk('0, '0, '0), (i < 32));
         step();
      end
      chk("drain_count", seen_tags.size(), 32);
      for (int i = 0; i < 32 && i < seen_tags.size(); i++)
         chk($sformatf("order_%0d", i), seen_tags[i], 10'(i));

      // Simultaneous push and pop at fillLevel 5.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, mk(128'(100 + i), 6'd5, 10'(100 + i)), 1'b0);
         step();
      end
      drive(1'b1, mk(128'd105, 6'd5, 10'd105), 1'b1);
      step();
      chk("pushpop_fill", bus.fillLevel, 5);
      seen_tags.delete();
      for (int i = 0; i < 5 + L; i++) begin
         drive(1'b0, mk('0, '0, '0), (i < 5));
         step();
      end
      chk("pushpop_count", seen_tags.size(), 6);
      if (seen_tags.size() == 6) chk("pushpop_last", seen_tags[5], 10'd105);

      // Mid-run asynchronous reset two cycles after a pop.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(128'(200 + i), 6'd3, 10'(200 + i)), 1'b0);
         step();
      end
      drive(1'b0, mk('0, '0, '0), 1'b1);
      step();
      drive(1'b0, mk('0, '0, '0), 1'b0);
      step();
      step();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_start", bus.start, 1'b0);
      chk("async_fill", bus.fillLevel, 0);
      chk("async_launched", bus.launchedCount, 0);
      chk("async_idle", bus.idleSlotCount, 0);
      chk("async_inReady", bus.inReady, 1'b0);
      @(negedge clk);
      drive(1'b1, mk(128'd9, 6'd9, 10'd9), 1'b1);
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0;
      drive(1'b0, mk('0, '0, '0), 1'b0);
      for (int i = 0; i < L + 2; i++) step();

      // Randomized traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(0, 99) < 55),
               mk({$urandom, $urandom, $urandom, $urandom}, 6'($urandom), 10'($urandom)),
               ($urandom_range(0, 99) < 45));
         step();
      end
      drive(1'b0, mk('0, '0, '0), 1'b0);
      for (int i = 0; i < L + 1; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
